button_event: RTL and testbench

Converts the debounced button level produced by the input filter into single-cycle event pulses: press, release, long-press, and auto-repeat while held. It sits directly downstream of the debounce filter, on the consumer end of its `button_clean` output. It feeds control logic, such as counters and mode selects, that needs one event per user action rather than a level. All outputs are registered and synchronous to `clk`.

---
 rtl/button_event_pkg.sv | 19 +
 rtl/button_event.sv | 111 +++++++++++
 tb/tb_button_event.sv | 139 +++++++++++++
 3 files changed

// File: rtl/button_event_pkg.sv
// button_event shared types.
// State encoding and the registered event bundle.
package button_event_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ARM     = 2'd0;
  localparam state_t IDLE    = 2'd1;
  localparam state_t PRESSED = 2'd2;
  localparam state_t LONG    = 2'd3;

  typedef struct packed {
    logic press;
    logic rel;
    logic lng;
    logic rpt;
  } ev_t;

endpackage

// File: rtl/button_event.sv
// button_event: debounced level to one-cycle press/release/
// long-press/repeat events, plus a held level.
module button_event
  import button_event_pkg::*;
#(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int CNT_W         = 26
) (
  input  logic clk,
  input  logic rstn,
  input  logic button_clean,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  if (LONG_CYCLES < 2) begin : g_long_chk
    $error("LONG_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_rpt_chk
    $error("REPEAT_CYCLES must be >= 2");
  end
  if ((64'd1 << CNT_W) <= 64'(LONG_CYCLES) ||
      (64'd1 << CNT_W) <= 64'(REPEAT_CYCLES)) begin : g_w_chk
    $error("CNT_W too narrow");
  end

  localparam logic [CNT_W-1:0] LONG_LAST =
    CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST =
    CNT_W'(REPEAT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ev_t              ev_q, ev_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ARM;
      cnt_q   <= '0;
      ev_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ev_q    <= ev_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARM: begin
        if (!button_clean) state_d = IDLE;
      end
      IDLE: begin
        if (button_clean) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        if (!button_clean) begin
          state_d = IDLE;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LONG: begin
        if (!button_clean) begin
          state_d = IDLE;
        end else if (cnt_q == RPT_LAST) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Release is tested first so it always beats long/repeat.
  always_comb begin
    ev_d = '0;
    unique case (state_q)
      ARM: ;
      IDLE: ev_d.press = button_clean;
      PRESSED: begin
        if (!button_clean)          ev_d.rel = 1'b1;
        else if (cnt_q == LONG_LAST) ev_d.lng = 1'b1;
      end
      LONG: begin
        if (!button_clean)         ev_d.rel = 1'b1;
        else if (cnt_q == RPT_LAST) ev_d.rpt = REPEAT_EN;
      end
    endcase
  end

  assign press         = ev_q.press;
  assign release_pulse = ev_q.rel;
  assign long_press    = ev_q.lng;
  assign repeat_pulse  = ev_q.rpt;
  assign held = (state_q == PRESSED) || (state_q == LONG);

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: directed scenarios plus random holds,
// two instances (repeat on/off) against a hold-length model.
module tb_button_event;

  localparam int L = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic bc = 1'b1;

  logic p1, r1, l1, t1, h1;
  logic p0, r0, l0, t0, h0;

  int passed = 0;
  int total = 0;

  // reference: acceptance flags plus hold length since press
  bit armed = 0;
  bit active = 0;
  int hold = 0;
  logic [4:0] exp1, exp0;

  always #5 clk = ~clk;

  button_event #(
    .LONG_CYCLES(L), .REPEAT_CYCLES(R),
    .REPEAT_EN(1'b1), .CNT_W(4)
  ) dut (
    .clk(clk), .rstn(rstn), .button_clean(bc),
    .press(p1), .release_pulse(r1), .long_press(l1),
    .repeat_pulse(t1), .held(h1)
  );

  button_event #(
    .LONG_CYCLES(L), .REPEAT_CYCLES(R),
    .REPEAT_EN(1'b0), .CNT_W(4)
  ) dut0 (
    .clk(clk), .rstn(rstn), .button_clean(bc),
    .press(p0), .release_pulse(r0), .long_press(l0),
    .repeat_pulse(t0), .held(h0)
  );

  function automatic void model(input bit b);
    bit pr, rl, lg, rp;
    pr = 0; rl = 0; lg = 0; rp = 0;
    if (!armed) begin
      armed = !b;
    end else if (!active) begin
      if (b) begin
        pr = 1; active = 1; hold = 0;
      end
    end else if (!b) begin
      rl = 1; active = 0;
    end else begin
      hold++;
      if (hold == L) lg = 1;
      else if (hold > L && (hold - L) % R == 0) rp = 1;
    end
    exp1 = {pr, rl, lg, rp, active};
    exp0 = {pr, rl, lg, 1'b0, active};
  endfunction

  task automatic check(input string tag);
    logic [4:0] o1, o0;
    o1 = {p1, r1, l1, t1, h1};
    o0 = {p0, r0, l0, t0, h0};
    total++;
    assert (o1 === exp1) passed++;
    else $error("FAIL %s en1 obs=%b exp=%b", tag, o1, exp1);
    total++;
    assert (o0 === exp0) passed++;
    else $error("FAIL %s en0 obs=%b exp=%b", tag, o0, exp0);
  endtask

  task automatic step(input bit b, input string tag);
    bc = b;
    @(posedge clk);
    #1;
    model(b);
    check(tag);
  endtask

  task automatic hold_for(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, tag);
    step(1'b0, tag);
  endtask

  initial begin
    exp1 = '0;
    exp0 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset");
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b1, "stuck_hi");
    step(1'b0, "arm_lo");
    step(1'b0, "idle");
    hold_for(5, "short5");
    step(1'b0, "gap");
    hold_for(20, "long20");
    step(1'b0, "gap");
    hold_for(L, "edge_rel");
    hold_for(1, "one_cyc");
    hold_for(2, "b2b");
    for (int k = 0; k < 30; k++) begin
      hold_for($urandom_range(1, 25), "rand_hold");
      for (int g = $urandom_range(0, 3); g > 0; g--)
        step(1'b0, "rand_gap");
    end
    // interrupt a hold with reset mid-cycle
    for (int i = 0; i < 10; i++) step(1'b1, "pre_rst");
    #2;
    rstn = 1'b0;
    armed = 0;
    active = 0;
    exp1 = '0;
    exp0 = '0;
    #1;
    check("rst_async");
    @(posedge clk);
    #1;
    check("rst_hold");
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) step(1'b1, "post_rst");
    step(1'b0, "rearm");
    hold_for(9, "final");
    step(1'b0, "tail");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=done");
    $fatal(1, "timeout");
  end

endmodule
